dff_bank_arbiter: RTL



---
 rtl/dff_bank_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared register bank with complementary outputs.
// Four level requesters; one grant at a time; one-cycle ack on write completion.
module dff_bank_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qn,
  output logic [1:0]         owner,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StGnt, StDone} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       owner_q;
  logic [3:0]       gnt_q;
  logic [3:0]       ack_q;
  logic [WIDTH-1:0] q_q;

  logic [WIDTH-1:0] slice [4];
  logic [1:0]       win;
  logic [1:0]       idx;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    assign slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    win = ptr_q;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) win = idx;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|req) begin
            gnt_q   <= 4'b0001 << win;
            owner_q <= win;
            state_q <= StGnt;
          end
        end
        StGnt: begin
          if (req[owner_q]) begin
            q_q     <= slice[owner_q];
            ack_q   <= 4'b0001 << owner_q;
            state_q <= StDone;
          end else begin
            // Abandoned request: release without writing, move past the owner.
            gnt_q   <= '0;
            ptr_q   <= owner_q + 2'd1;
            state_q <= StIdle;
          end
        end
        StDone: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          ptr_q   <= owner_q + 2'd1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign q     = q_q;
  assign qn    = ~q_q;
  assign owner = owner_q;
  assign busy  = (state_q != StIdle);

endmodule
